// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU_OT result classes and flag bit positions.
// Used by the ALU, the decoder and the register-file writeback stage.
package cpu_pkg;

   localparam int DATA_W = 16;
   localparam int ADDR_W = 3;
   localparam int NREGS  = 8;
   localparam int CNT_W  = 16;

   localparam logic [1:0] OT_MOVE  = 2'b00;
   localparam logic [1:0] OT_ARITH = 2'b01;
   localparam logic [1:0] OT_LOGIC = 2'b10;
   localparam logic [1:0] OT_NOP   = 2'b11;

   localparam int FLG_ZA = 4;
   localparam int FLG_ZB = 3;
   localparam int FLG_EQ = 2;
   localparam int FLG_GT = 1;
   localparam int FLG_LT = 0;

   typedef struct packed {
      logic za;
      logic zb;
      logic eq;
      logic gt;
      logic lt;
   } alu_flags_t;

   // OT_NOP beats carry no architectural effect at all.
   function automatic logic is_commit(input logic valid, input logic [1:0] ot);
      return valid && (ot != OT_NOP);
   endfunction

endpackage

// File: rtl/regfile_writeback_if.sv
// Issue, ALU writeback and operand-read bus between the pipeline and the register file.
// All signals are single-beat: a valid is acted on at the rising edge it is seen high.
interface regfile_writeback_if #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int ADDR_W = cpu_pkg::ADDR_W
);

   logic              iss_valid;
   logic [ADDR_W-1:0] iss_addr;
   logic              iss_conflict;

   logic              wb_valid;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic [1:0]        wb_ot;
   logic [4:0]        wb_flags;

   logic [ADDR_W-1:0] rd1_addr;
   logic [ADDR_W-1:0] rd2_addr;
   logic [DATA_W-1:0] rd1_data;
   logic [DATA_W-1:0] rd2_data;
   logic              rd1_busy;
   logic              rd2_busy;

   // Handshake: an issue is taken when iss_valid is high and iss_conflict is low at the edge;
   // on conflict the decoder holds iss_valid/iss_addr and retries. Writeback has no back-pressure.
   modport master (
      output iss_valid, iss_addr,
      output wb_valid, wb_addr, wb_data, wb_ot, wb_flags,
      output rd1_addr, rd2_addr,
      input  iss_conflict, rd1_data, rd2_data, rd1_busy, rd2_busy
   );

   modport slave (
      input  iss_valid, iss_addr,
      input  wb_valid, wb_addr, wb_data, wb_ot, wb_flags,
      input  rd1_addr, rd2_addr,
      output iss_conflict, rd1_data, rd2_data, rd1_busy, rd2_busy
   );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write tracker: busy vector, issue conflict detection and the
// sticky error for writebacks that arrive without a matching issue.
module reg_scoreboard #(
   parameter int NREGS  = cpu_pkg::NREGS,
   parameter int ADDR_W = cpu_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   input  logic              commit,
   input  logic [ADDR_W-1:0] wb_addr,
   output logic              iss_conflict,
   output logic [NREGS-1:0]  busy,
   output logic              wb_err
);

   logic             clear_hit;
   logic             accept;
   logic [NREGS-1:0] busy_nxt;

   // A register retiring this cycle is free for a new issue at the same edge.
   assign clear_hit    = commit && (wb_addr == iss_addr);
   assign iss_conflict = iss_valid && busy[iss_addr] && !clear_hit;
   assign accept       = iss_valid && !iss_conflict;

   always_comb begin
      busy_nxt = busy;
      if (commit) busy_nxt[wb_addr] = 1'b0;
      if (accept) busy_nxt[iss_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy   <= '0;
         wb_err <= 1'b0;
      end else begin
         busy <= busy_nxt;
         if (commit && !busy[wb_addr]) wb_err <= 1'b1;
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// ALU result consumer: commits results into an 8x16 register file and the status flags,
// and serves two bypassed operand read ports alongside the pending-write scoreboard.
module regfile_writeback #(
   parameter int DATA_W = cpu_pkg::DATA_W,
   parameter int NREGS  = cpu_pkg::NREGS,
   parameter int ADDR_W = cpu_pkg::ADDR_W,
   parameter int CNT_W  = cpu_pkg::CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   regfile_writeback_if.slave bus,
   output logic [4:0]         flags_out,
   output logic               wb_err,
   output logic [CNT_W-1:0]   retired_cnt
);

   import cpu_pkg::*;

   logic              commit;
   logic [NREGS-1:0]  busy;
   logic [DATA_W-1:0] regs [NREGS];

   assign commit = is_commit(bus.wb_valid, bus.wb_ot);

   reg_scoreboard #(
      .NREGS  (NREGS),
      .ADDR_W (ADDR_W)
   ) u_scoreboard (
      .clk          (clk),
      .rst_n        (rst_n),
      .iss_valid    (bus.iss_valid),
      .iss_addr     (bus.iss_addr),
      .commit       (commit),
      .wb_addr      (bus.wb_addr),
      .iss_conflict (bus.iss_conflict),
      .busy         (busy),
      .wb_err       (wb_err)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (commit) begin
         regs[bus.wb_addr] <= bus.wb_data;
      end
   end

   // Only logic-class results update the status flags; move/arith keep the old ones.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_out   <= '0;
         retired_cnt <= '0;
      end else if (commit) begin
         retired_cnt <= retired_cnt + CNT_W'(1);
         if (bus.wb_ot == OT_LOGIC) flags_out <= bus.wb_flags;
      end
   end

   // Same-cycle writeback is forwarded and reported as no longer pending.
   always_comb begin
      bus.rd1_data = regs[bus.rd1_addr];
      bus.rd1_busy = busy[bus.rd1_addr];
      if (commit && (bus.rd1_addr == bus.wb_addr)) begin
         bus.rd1_data = bus.wb_data;
         bus.rd1_busy = 1'b0;
      end
      bus.rd2_data = regs[bus.rd2_addr];
      bus.rd2_busy = busy[bus.rd2_addr];
      if (commit && (bus.rd2_addr == bus.wb_addr)) begin
         bus.rd2_data = bus.wb_data;
         bus.rd2_busy = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and random bench for regfile_writeback with a behavioural reference model
// and a writeback scoreboard read back through the operand ports.
module tb_regfile_writeback;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  flags_out;
   logic        wb_err;
   logic [15:0] retired_cnt;

   always #5 clk = ~clk;

   regfile_writeback_if bus ();

   regfile_writeback dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus),
      .flags_out   (flags_out),
      .wb_err      (wb_err),
      .retired_cnt (retired_cnt)
   );

   int total = 0;
   int bad   = 0;

   logic [15:0] m_regs [8];
   logic [7:0]  m_busy;
   logic [4:0]  m_flags;
   logic        m_err;
   logic [15:0] m_cnt;
   logic [15:0] exp_q [$];
   logic [2:0]  exp_a [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_busy  = 8'h0;
      m_flags = 5'h0;
      m_err   = 1'b0;
      m_cnt   = 16'h0;
      exp_q.delete();
      exp_a.delete();
   endtask

   task automatic idle_inputs();
      bus.iss_valid = 1'b0;
      bus.iss_addr  = 3'd0;
      bus.wb_valid  = 1'b0;
      bus.wb_addr   = 3'd0;
      bus.wb_data   = 16'h0;
      bus.wb_ot     = 2'b00;
      bus.wb_flags  = 5'h0;
   endtask

   // One clock: drive, check combinational outputs against the model, step the model,
   // take the edge, check registered outputs, then read back every committed result.
   task automatic beat(input logic iv, input logic [2:0] ia,
                       input logic wv, input logic [2:0] wa, input logic [15:0] wd,
                       input logic [1:0] ot, input logic [4:0] wf,
                       input logic [2:0] r1, input logic [2:0] r2);
      logic        cm;
      logic        conf;
      logic [15:0] e1;
      logic [15:0] e2;
      logic        b1;
      logic        b2;
      logic [15:0] d;
      logic [2:0]  a;
      bus.iss_valid = iv;
      bus.iss_addr  = ia;
      bus.wb_valid  = wv;
      bus.wb_addr   = wa;
      bus.wb_data   = wd;
      bus.wb_ot     = ot;
      bus.wb_flags  = wf;
      bus.rd1_addr  = r1;
      bus.rd2_addr  = r2;
      #1;
      cm   = wv && (ot != 2'b11);
      conf = iv && m_busy[ia] && !(cm && (wa == ia));
      e1   = (cm && (r1 == wa)) ? wd : m_regs[r1];
      b1   = (cm && (r1 == wa)) ? 1'b0 : m_busy[r1];
      e2   = (cm && (r2 == wa)) ? wd : m_regs[r2];
      b2   = (cm && (r2 == wa)) ? 1'b0 : m_busy[r2];
      check("iss_conflict", 32'(bus.iss_conflict), 32'(conf));
      check("rd1_data", 32'(bus.rd1_data), 32'(e1));
      check("rd1_busy", 32'(bus.rd1_busy), 32'(b1));
      check("rd2_data", 32'(bus.rd2_data), 32'(e2));
      check("rd2_busy", 32'(bus.rd2_busy), 32'(b2));
      if (cm) begin
         if (!m_busy[wa]) m_err = 1'b1;
         m_regs[wa] = wd;
         m_busy[wa] = 1'b0;
         m_cnt++;
         if (ot == 2'b10) m_flags = wf;
         exp_q.push_back(wd);
         exp_a.push_back(wa);
      end
      if (iv && !conf) m_busy[ia] = 1'b1;
      @(posedge clk);
      #1;
      idle_inputs();
      #1;
      check("flags_out", 32'(flags_out), 32'(m_flags));
      check("wb_err", 32'(wb_err), 32'(m_err));
      check("retired_cnt", 32'(retired_cnt), 32'(m_cnt));
      while (exp_q.size() > 0) begin
         d = exp_q.pop_front();
         a = exp_a.pop_front();
         bus.rd2_addr = a;
         #1;
         check("reg_readback", 32'(bus.rd2_data), 32'(d));
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rst_n = 1'b0;
      idle_inputs();
      bus.rd1_addr = 3'd0;
      bus.rd2_addr = 3'd4;
      model_reset();
      #12;
      check("reset_flags", 32'(flags_out), 32'h0);
      check("reset_err", 32'(wb_err), 32'h0);
      check("reset_cnt", 32'(retired_cnt), 32'h0);
      check("reset_rd1", 32'(bus.rd1_data), 32'h0);
      check("reset_busy", 32'(bus.rd2_busy), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // basic commit: busy before the wb edge, bypass during it
      beat(1'b1, 3'd2, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd2, 3'd0);
      beat(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd2, 3'd2);
      beat(1'b0, 3'd0, 1'b1, 3'd2, 16'h1234, 2'b01, 5'h0, 3'd2, 3'd3);
      check("basic_cnt", 32'(retired_cnt), 32'd1);

      // flag gating
      beat(1'b1, 3'd1, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd1, 3'd2);
      beat(1'b0, 3'd0, 1'b1, 3'd1, 16'hAAAA, 2'b10, 5'b10100, 3'd1, 3'd2);
      check("flags_logic", 32'(flags_out), 32'(5'b10100));
      beat(1'b1, 3'd1, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd1, 3'd2);
      beat(1'b0, 3'd0, 1'b1, 3'd1, 16'hBBBB, 2'b01, 5'b01011, 3'd1, 3'd2);
      beat(1'b0, 3'd0, 1'b1, 3'd1, 16'hDEAD, 2'b11, 5'b11111, 3'd1, 3'd1);
      check("nop_flags", 32'(flags_out), 32'(5'b10100));
      check("nop_cnt", 32'(retired_cnt), 32'd3);

      // hazards
      beat(1'b1, 3'd5, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd5, 3'd5);
      beat(1'b1, 3'd5, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd5, 3'd0);
      beat(1'b1, 3'd5, 1'b1, 3'd5, 16'h5555, 2'b00, 5'h0, 3'd5, 3'd6);
      beat(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd5, 3'd5);
      beat(1'b0, 3'd0, 1'b1, 3'd5, 16'h5A5A, 2'b01, 5'h0, 3'd5, 3'd0);
      check("err_clean", 32'(wb_err), 32'h0);

      // unmatched writeback
      beat(1'b0, 3'd0, 1'b1, 3'd7, 16'h7777, 2'b00, 5'h0, 3'd7, 3'd0);
      beat(1'b0, 3'd0, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd7, 3'd6);
      check("err_sticky", 32'(wb_err), 32'h1);

      for (int i = 0; i < 40; i++) begin
         beat(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
              2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
              3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end

      // reset mid-operation, between edges
      beat(1'b1, 3'd3, 1'b0, 3'd0, 16'h0, 2'b00, 5'h0, 3'd3, 3'd0);
      beat(1'b0, 3'd0, 1'b1, 3'd3, 16'h00FF, 2'b01, 5'h0, 3'd3, 3'd0);
      bus.iss_valid = 1'b1;
      bus.iss_addr  = 3'd3;
      #2;
      rst_n = 1'b0;
      bus.rd1_addr = 3'd3;
      #1;
      check("midrst_rd1", 32'(bus.rd1_data), 32'h0);
      check("midrst_busy", 32'(bus.rd1_busy), 32'h0);
      check("midrst_cnt", 32'(retired_cnt), 32'h0);
      check("midrst_err", 32'(wb_err), 32'h0);
      model_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // counter wrap
      for (int i = 0; i < 65535; i++) begin
         bus.wb_valid = 1'b1;
         bus.wb_ot    = 2'b01;
         bus.wb_addr  = 3'd0;
         bus.wb_data  = i[15:0];
         @(posedge clk);
         #1;
      end
      idle_inputs();
      m_cnt     = 16'hFFFF;
      m_regs[0] = 16'hFFFE;
      m_err     = 1'b1;
      #1;
      check("cnt_max", 32'(retired_cnt), 32'hFFFF);
      beat(1'b0, 3'd0, 1'b1, 3'd0, 16'hABCD, 2'b01, 5'h0, 3'd0, 3'd1);
      check("cnt_wrap", 32'(retired_cnt), 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Consumer end of the ALU result interface.
- Captures ALU result, destination register address, ALU_OT class and compare flags.
- Commits them into an 8x16 general-purpose register file and a status-flag register.
- Serves the two operand read ports that feed op1/op2, with same-cycle write bypass.
- Keeps a per-register pending-write scoreboard so issue logic can detect RAW/WAW hazards.

Parameters:
- DATA_W, 16, register and result width
- NREGS, 8, number of general-purpose registers
- ADDR_W, 3, register address width (log2 NREGS)
- CNT_W, 16, width of retired-writeback counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- iss_valid  in  1  decoder issues an instruction with destination iss_addr
- iss_addr  in  ADDR_W  destination register of issued instruction
- iss_conflict  out  1  issue refused; destination already pending (combinational)
- wb_valid  in  1  ALU result present this cycle
- wb_addr  in  ADDR_W  destination register (ALU Addr_out)
- wb_data  in  DATA_W  result (ALU_out)
- wb_ot  in  2  ALU_OT class of the result
- wb_flags  in  5  {za,zb,eq,gt,lt} from ALU
- rd1_addr, rd2_addr  in  ADDR_W  operand read addresses
- rd1_data, rd2_data  out  DATA_W  operand data (combinational)
- rd1_busy, rd2_busy  out  1  operand has an outstanding write (combinational)
- flags_out  out  5  committed {za,zb,eq,gt,lt}
- wb_err  out  1  sticky: writeback to a register with no pending write
- retired_cnt  out  CNT_W  count of committed writebacks

Behaviour:
- Reset (async, rst_n=0): all registers 0, busy bits 0, flags_out 0, wb_err 0, retired_cnt 0. Effect is immediate. Any in-flight issue or writeback is discarded. No state change until the first rising edge after deassertion.
- Effective writeback: commit = wb_valid & (wb_ot != 2'b11). OT 11 is the ALU null class and is ignored completely: no write, no busy change, no count, no flag change.
- On commit at a rising edge:
  - reg[wb_addr] <= wb_data
  - busy[wb_addr] <= 0, unless re-set by a same-cycle issue
  - retired_cnt += 1, wrapping from 2^CNT_W-1 to 0
- Flags: flags_out <= wb_flags only when commit and wb_ot == 2'b10 (logic class). OT 00 and 01 hold the previous flags.
- wb_err: set at a commit edge if busy[wb_addr] == 0 before the edge. The write still happens. Cleared only by reset.
- Issue:
  - accepted = iss_valid & ~iss_conflict; on accept, busy[iss_addr] <= 1.
  - iss_conflict = iss_valid & busy[iss_addr] & ~(commit & wb_addr == iss_addr).
  - An issue that hits a register being written back in the same cycle is accepted, and its busy bit stays 1 (the issue wins over the clear).
  - A conflicted issue changes nothing. The decoder holds and retries.
- Reads: zero-latency combinational. If commit and rdN_addr == wb_addr, rdN_data = wb_data and rdN_busy = 0 (bypass). Otherwise rdN_data = reg[rdN_addr] and rdN_busy = busy[rdN_addr].
- Same-cycle issue to X and read of X: the read sees pre-edge busy, not the new issue.
- Both read ports may hit the same address. Each port is independent.
- No register is hard-wired; r0 is writable.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W, ADDR_W
  - ALU_OT encodings: OT_MOVE=2'b00, OT_ARITH=2'b01, OT_LOGIC=2'b10, OT_NOP=2'b11
  - flag bit indices: FLG_ZA=4, FLG_ZB=3, FLG_EQ=2, FLG_GT=1, FLG_LT=0
  - The ALU and the decoder use the same package.
- Sub-module reg_scoreboard (busy vector, iss_conflict, issue/clear priority, wb_err) is natural. The data array, bypass, flags and counter stay in the top.

Test Plan:
- Reset mid-operation:
  - Stimulus: issue r3, write r3=16'h00FF, then pull rst_n low between edges.
  - Response: rd1_data(r3)=0, busy 0, retired_cnt 0 immediately.
- Basic commit:
  - Stimulus: issue r2; next cycle wb r2=16'h1234, ot=01.
  - Response: rd1_busy(r2)=1 before the wb edge. During the wb cycle, rd1_data=16'h1234 (bypass) and busy=0. After the edge, reg holds 16'h1234, retired_cnt=1, wb_err=0.
- Flag gating:
  - Stimulus: wb ot=10, flags=5'b10100; then wb ot=01, flags=5'b01011; then wb_valid=1, ot=11.
  - Response: flags_out=5'b10100 after the first and stays there. The ot=11 beat leaves the register and retired_cnt unchanged.
- Hazard:
  - Stimulus: issue r5, then issue r5 again.
  - Response: iss_conflict=1 on the second issue.
  - Stimulus: same cycle as a wb to r5, issue r5.
  - Response: iss_conflict=0, and busy(r5) remains 1 after the edge.
- Error and wrap:
  - Stimulus: wb to r7 with no prior issue.
  - Response: write occurs, wb_err=1 and sticky.
  - Stimulus: preload retired_cnt to 16'hFFFF via 65535 commits, then one more commit.
  - Response: retired_cnt=0.
